// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller
// (master) and instruction memory (slave).
interface inst_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             inst_req;
    logic [WIDTH-1:0] inst_addr;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [31:0]      inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: issues one outstanding request per PC,
// buffers the returned instruction for ID, and drops wrong-path data on flush.
module inst_fetch_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          pc,
    input  logic                      flush,
    output logic                      pc_en,
    inst_fetch_ctrl_if.master         imem,
    output logic                      id_valid,
    output logic [WIDTH-1:0]          id_pc,
    output logic [31:0]               id_inst,
    input  logic                      id_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        CANCEL
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] req_pc;
    logic             req;
    logic             hs;
    logic             capture;

    assign imem.inst_req  = req;
    assign imem.inst_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, request/enable outputs and capture decision
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        hs       = 1'b0;
        pc_en    = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                state_nx = REQ;
            end
            REQ: begin
                req = (!id_valid || id_ready) && !flush;
                hs  = req && imem.inst_addr_ok;
                if (hs) begin
                    pc_en    = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nx = imem.inst_data_ok ? REQ : CANCEL;
                end else if (imem.inst_data_ok) begin
                    capture  = 1'b1;
                    state_nx = REQ;
                end
            end
            CANCEL: begin
                // The cancelled response retires the outstanding request even
                // if another flush arrives with it; nothing else is in flight.
                if (imem.inst_data_ok) begin
                    state_nx = REQ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Remember the address of the outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc <= '0;
        end else if (hs) begin
            req_pc <= pc;
        end
    end

    // One-entry output buffer toward ID
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (capture) begin
            id_valid <= 1'b1;
            id_pc    <= req_pc;
            id_inst  <= imem.inst_rdata;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed, table-driven bench for inst_fetch_ctrl.
module tb_inst_fetch_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] pc;
    logic             flush;
    logic             pc_en;
    logic             id_valid;
    logic [WIDTH-1:0] id_pc;
    logic [31:0]      id_inst;
    logic             id_ready;

    int checks;
    int errors;

    inst_fetch_ctrl_if #(.WIDTH(WIDTH)) bus ();

    inst_fetch_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .flush    (flush),
        .pc_en    (pc_en),
        .imem     (bus),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] pc;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic        en;
        logic        vld;
        logic [31:0] idpc;
        logic [31:0] idinst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_i, input logic fl_i, input logic [31:0] pc_i,
        input logic aok_i, input logic dok_i, input logic [31:0] rd_i,
        input logic rdy_i, input logic req_i, input logic en_i,
        input logic vld_i, input logic [31:0] idpc_i, input logic [31:0] idinst_i);
        vec_t v;
        v.rst = rst_i;   v.flush = fl_i;  v.pc = pc_i;
        v.aok = aok_i;   v.dok = dok_i;   v.rdata = rd_i;
        v.rdy = rdy_i;   v.req = req_i;   v.en = en_i;
        v.vld = vld_i;   v.idpc = idpc_i; v.idinst = idinst_i;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [31:0] p,
                         input logic aok, input logic dok, input logic [31:0] rd,
                         input logic rdy);
        rst               = r;
        flush             = f;
        pc                = p;
        bus.inst_addr_ok  = aok;
        bus.inst_data_ok  = dok;
        bus.inst_rdata    = rd;
        id_ready          = rdy;
    endtask

    localparam logic [31:0] I0   = 32'hA000_0000;
    localparam logic [31:0] I4   = 32'hA000_0004;
    localparam logic [31:0] I8   = 32'hA000_0008;
    localparam logic [31:0] I300 = 32'hA000_0300;
    localparam logic [31:0] I308 = 32'hA000_0308;
    localparam logic [31:0] I30C = 32'hC0DE_030C;

    initial begin
        bit seen;
        checks = 0;
        errors = 0;

        //           rst fl pc        aok dok rdata         rdy  req en vld idpc     idinst
        // basic fetch stream, k=1
        vecs.push_back(mk(0, 0, 32'h000, 1, 0, 32'h0,        1,   0, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 32'h000, 1, 0, 32'h0,        1,   1, 1, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 32'h004, 1, 1, I0,           1,   0, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 32'h004, 1, 0, 32'h0,        1,   1, 1, 1, 32'h0,   I0));
        vecs.push_back(mk(0, 0, 32'h008, 1, 1, I4,           1,   0, 0, 0, 32'h0,   I0));
        vecs.push_back(mk(0, 0, 32'h008, 1, 0, 32'h0,        1,   1, 1, 1, 32'h4,   I4));
        vecs.push_back(mk(0, 0, 32'h00C, 1, 1, I8,           1,   0, 0, 0, 32'h4,   I4));
        // backpressure for 5 cycles, then release
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 32'h00C, 1, 0, 32'h0,    0,   0, 0, 1, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h00C, 1, 0, 32'h0,        1,   1, 1, 1, 32'h8,   I8));
        // flush together with data_ok in WAIT: dropped
        vecs.push_back(mk(0, 1, 32'h010, 1, 1, 32'hCCCC_000C, 1,  0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h100, 0, 0, 32'h0,        1,   1, 0, 0, 32'h8,   I8));
        // flush in REQ with addr_ok: no handshake
        vecs.push_back(mk(0, 1, 32'h100, 1, 0, 32'h0,        1,   0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h200, 1, 0, 32'h0,        1,   1, 1, 0, 32'h8,   I8));
        // flush in WAIT, stale data three cycles later
        vecs.push_back(mk(0, 1, 32'h204, 1, 0, 32'h0,        1,   0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h300, 1, 0, 32'h0,        1,   0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h300, 1, 0, 32'h0,        1,   0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h300, 1, 1, 32'hDEAD_BEEF, 1,  0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h300, 1, 0, 32'h0,        1,   1, 1, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h304, 1, 1, I300,         1,   0, 0, 0, 32'h8,   I8));
        vecs.push_back(mk(0, 0, 32'h304, 0, 0, 32'h0,        1,   1, 0, 1, 32'h300, I300));
        // stray data_ok in REQ ignored
        vecs.push_back(mk(0, 0, 32'h304, 0, 1, 32'h1234_5678, 1,  1, 0, 0, 32'h300, I300));
        // reset in WAIT (with data_ok), then restart
        vecs.push_back(mk(0, 0, 32'h304, 1, 0, 32'h0,        1,   1, 1, 0, 32'h300, I300));
        vecs.push_back(mk(1, 0, 32'h308, 1, 1, 32'h55,       1,   0, 0, 0, 32'h300, I300));
        vecs.push_back(mk(0, 0, 32'h308, 1, 0, 32'h0,        1,   0, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 32'h308, 1, 0, 32'h0,        1,   1, 1, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 32'h30C, 1, 1, I308,         1,   0, 0, 0, 32'h0,   32'h0));
        // reset while the buffer holds a stalled instruction
        vecs.push_back(mk(0, 0, 32'h30C, 1, 0, 32'h0,        0,   0, 0, 1, 32'h308, I308));
        vecs.push_back(mk(1, 0, 32'h30C, 1, 0, 32'h0,        0,   0, 0, 1, 32'h308, I308));
        vecs.push_back(mk(0, 0, 32'h30C, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 32'h30C, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0,   32'h0));

        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].flush, vecs[i].pc, vecs[i].aok,
                  vecs[i].dok, vecs[i].rdata, vecs[i].rdy);
            @(negedge clk);
            check("inst_req", i, {31'b0, bus.inst_req}, {31'b0, vecs[i].req});
            check("pc_en",    i, {31'b0, pc_en},        {31'b0, vecs[i].en});
            check("id_valid", i, {31'b0, id_valid},     {31'b0, vecs[i].vld});
            check("id_pc",    i, id_pc,                 vecs[i].idpc);
            check("id_inst",  i, id_inst,               vecs[i].idinst);
            if (vecs[i].req)
                check("inst_addr", i, bus.inst_addr, vecs[i].pc);
        end

        // Long memory latency (k=4) for the request issued at 0x30C
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive(0, 0, 32'h310, 1, 0, 32'h0, 0);
            @(negedge clk);
            check("wait_req", 100 + i, {31'b0, bus.inst_req}, 32'h0);
            check("wait_en",  100 + i, {31'b0, pc_en},        32'h0);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 32'h310, 1, 1, I30C, 0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk);
            #1;
            drive(0, 0, 32'h310, 1, 0, 32'h0, 0);
            @(negedge clk);
            seen = id_valid;
        end
        check("late_valid", 200, {31'b0, seen}, 32'h1);
        check("late_pc",    201, id_pc,         32'h30C);
        check("late_inst",  202, id_inst,       I30C);
        check("late_stall", 203, {31'b0, bus.inst_req}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
